discharge_sequencer: RTL and testbench

- Scheduler that feeds machining parameter sets (waveform, Ip, Ton, Toff) and the run enable to the discharge MOSFET controller.
- Holds a small host-loaded table of sets and steps through them by completed-pulse count.
- Switches sets only at the start of an inter-pulse (deion) interval, so a discharge never sees mid-pulse parameter changes.
- Handles start/stop commands and fault shutdown.

---
 rtl/discharge_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_discharge_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/discharge_sequencer.sv
// Parameter-set scheduler for the discharge MOSFET controller: steps through a host-loaded
// table by pulse count, switching sets only at deion start. Optional build macro: SCHED_LOOP_EN.
module discharge_sequencer #(
  parameter int          NUM_SETS      = 4,
  parameter int          PTR_W         = 2,
  parameter logic [15:0] DRAIN_TIMEOUT = 16'd5000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr_en,
  input  logic [PTR_W-1:0] cfg_wr_addr,
  input  logic [63:0]      cfg_wr_data,
  input  logic [15:0]      cfg_wr_pulses,
  input  logic [PTR_W-1:0] cfg_last_idx,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             deion_start,
  input  logic             pulse_done,
  input  logic             fault_in,
  output logic             is_machine,
  output logic [15:0]      waveform,
  output logic [15:0]      Ip,
  output logic [15:0]      Ton,
  output logic [15:0]      Toff,
  output logic [PTR_W-1:0] active_idx,
  output logic [15:0]      pulse_cnt,
  output logic             busy,
  output logic             seq_done,
  output logic             fault_latched,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_SWITCH = 2'd2, S_DRAIN = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [63:0]      tbl_q        [NUM_SETS];
  logic [15:0]      tbl_pulses_q [NUM_SETS];
  logic [63:0]      params_q, params_d;
  logic [15:0]      limit_q, limit_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      drain_q, drain_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             flt_q, flt_d;

  logic             load_en, do_switch, last_pulse;
  logic [PTR_W-1:0] load_idx, next_idx;
  logic [15:0]      cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        tbl_q[i]        <= '0;
        tbl_pulses_q[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      tbl_q[cfg_wr_addr]        <= cfg_wr_data;
      tbl_pulses_q[cfg_wr_addr] <= cfg_wr_pulses;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      params_q <= '0;
      limit_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      params_q <= params_d;
      limit_q  <= limit_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      run_q    <= run_d;
      done_q   <= done_d;
      flt_q    <= flt_d;
    end
  end

  // Priority: fault, then stop, then pulse/deion events. Loads are applied last so a
  // load always overrides the counter update made earlier in the same cycle.
  always_comb begin
    state_d    = state_q;
    params_d   = params_q;
    limit_d    = limit_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    run_d      = run_q;
    done_d     = 1'b0;
    flt_d      = flt_q;
    load_en    = 1'b0;
    load_idx   = '0;
    do_switch  = 1'b0;
    next_idx   = idx_q + PTR_W'(1);
    cnt_inc    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    last_pulse = (limit_q != 16'd0) && (({1'b0, cnt_q} + 17'd1) == {1'b0, limit_q});

    if (state_q == S_IDLE) begin
      if (!cmd_stop && cmd_start && !fault_in) begin
        load_en = 1'b1;
        flt_d   = 1'b0;
        run_d   = 1'b1;
        state_d = S_RUN;
      end
    end else if (fault_in && state_q != S_DRAIN) begin
      run_d   = 1'b0;
      flt_d   = 1'b1;
      drain_d = '0;
      state_d = S_DRAIN;
    end else if (cmd_stop && state_q != S_DRAIN) begin
      run_d   = 1'b0;
      drain_d = '0;
      state_d = S_DRAIN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (pulse_done) begin
            cnt_d = cnt_inc;
            if (last_pulse) begin
              if (deion_start) do_switch = 1'b1;
              else             state_d   = S_SWITCH;
            end
          end
        end
        S_SWITCH: begin
          if (deion_start) do_switch = 1'b1;
        end
        S_DRAIN: begin
          if (fault_in) flt_d = 1'b1;
          if (deion_start || drain_q == DRAIN_TIMEOUT - 16'd1) state_d = S_IDLE;
          else                                                  drain_d = drain_q + 16'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (do_switch) begin
      if (idx_q < cfg_last_idx) begin
        load_en  = 1'b1;
        load_idx = next_idx;
        state_d  = S_RUN;
      end else begin
        done_d = 1'b1;
`ifdef SCHED_LOOP_EN
        load_en = 1'b1;
        state_d = S_RUN;
`else
        run_d   = 1'b0;
        state_d = S_IDLE;
`endif
      end
    end

    if (load_en) begin
      params_d = tbl_q[load_idx];
      limit_d  = tbl_pulses_q[load_idx];
      idx_d    = load_idx;
      cnt_d    = '0;
    end
  end

  assign is_machine    = run_q;
  assign waveform      = params_q[63:48];
  assign Ip            = params_q[47:32];
  assign Ton           = params_q[31:16];
  assign Toff          = params_q[15:0];
  assign active_idx    = idx_q;
  assign pulse_cnt     = cnt_q;
  assign busy          = (state_q != S_IDLE);
  assign seq_done      = done_q;
  assign fault_latched = flt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_discharge_sequencer.sv
// Directed bench for discharge_sequencer; honours SCHED_LOOP_EN when the build defines it.
module tb_discharge_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr_en;
  logic [1:0]  cfg_wr_addr;
  logic [63:0] cfg_wr_data;
  logic [15:0] cfg_wr_pulses;
  logic [1:0]  cfg_last_idx;
  logic        cmd_start, cmd_stop, deion_start, pulse_done, fault_in;
  logic        is_machine, busy, seq_done, fault_latched;
  logic [15:0] waveform, Ip, Ton, Toff, pulse_cnt;
  logic [1:0]  active_idx, dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int n;

  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  discharge_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_pulses(cfg_wr_pulses), .cfg_last_idx(cfg_last_idx),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .deion_start(deion_start),
    .pulse_done(pulse_done), .fault_in(fault_in),
    .is_machine(is_machine), .waveform(waveform), .Ip(Ip), .Ton(Ton), .Toff(Toff),
    .active_idx(active_idx), .pulse_cnt(pulse_cnt), .busy(busy), .seq_done(seq_done),
    .fault_latched(fault_latched), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_entry(input logic [1:0] a, input logic [15:0] wf, input logic [15:0] ip,
                          input logic [15:0] ton, input logic [15:0] toff, input logic [15:0] p);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = {wf, ip, ton, toff}; cfg_wr_pulses = p;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic start();
    cmd_start = 1'b1; step(); cmd_start = 1'b0;
  endtask

  task automatic stop();
    cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
  endtask

  task automatic pulse();
    pulse_done = 1'b1; step(); pulse_done = 1'b0;
  endtask

  task automatic deion();
    deion_start = 1'b1; step(); deion_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; cfg_wr_pulses = '0;
    cfg_last_idx = '0; cmd_start = 1'b0; cmd_stop = 1'b0; deion_start = 1'b0;
    pulse_done = 1'b0; fault_in = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset state
    check("rst_is_machine", is_machine, 0);
    check("rst_busy", busy, 0);
    check("rst_ip", Ip, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_fault", fault_latched, 0);
    check("rst_idx", active_idx, 0);

    // two-entry sequence
    wr_entry(2'd0, 16'h0001, 16'd20, 16'd50, 16'd100, 16'd3);
    wr_entry(2'd1, 16'h0002, 16'd30, 16'd40, 16'd80, 16'd2);
    cfg_last_idx = 2'd1;
    start();
    check("start_is_machine", is_machine, 1);
    check("start_wave", waveform, 16'h0001);
    check("start_ip", Ip, 20);
    check("start_ton", Ton, 50);
    check("start_toff", Toff, 100);
    check("start_busy", busy, 1);
    check("start_cnt", pulse_cnt, 0);

    wr_entry(2'd0, 16'h0001, 16'd99, 16'd50, 16'd100, 16'd3);
    check("rewrite_ip_hold", Ip, 20);

    repeat (3) pulse();
    check("e0_cnt", pulse_cnt, 3);
    check("e0_switch_state", dbg_state, ST_SWITCH);
    check("e0_ip_hold", Ip, 20);
    pulse();
    check("switch_ignore_pulse", pulse_cnt, 3);

    deion();
    check("e1_ip", Ip, 30);
    check("e1_ton", Ton, 40);
    check("e1_idx", active_idx, 1);
    check("e1_cnt", pulse_cnt, 0);
    check("e1_is_machine", is_machine, 1);

    repeat (2) pulse();
    deion();
    check("end_seq_done", seq_done, 1);
`ifdef SCHED_LOOP_EN
    check("loop_is_machine", is_machine, 1);
    check("loop_idx", active_idx, 0);
    check("loop_ip", Ip, 99);
    check("loop_state", dbg_state, ST_RUN);
    step();
    check("loop_seq_done_once", seq_done, 0);
    stop();
    deion();
    check("loop_stop_busy", busy, 0);
`else
    check("end_is_machine", is_machine, 0);
    check("end_busy", busy, 0);
    check("end_ip_hold", Ip, 30);
    step();
    check("end_seq_done_once", seq_done, 0);
`endif

    // fault shutdown and restart
    start();
    check("f_run", is_machine, 1);
    fault_in = 1'b1;
    step();
    check("f_is_machine", is_machine, 0);
    check("f_latched", fault_latched, 1);
    deion();
    check("f_drain_exit", busy, 0);
    start();
    check("f_start_ignored_busy", busy, 0);
    check("f_start_ignored_latch", fault_latched, 1);
    fault_in = 1'b0;
    step();
    start();
    check("f_restart_latch", fault_latched, 0);
    check("f_restart_run", is_machine, 1);

    // stop with drain timeout
    stop();
    check("to_is_machine", is_machine, 0);
    check("to_busy", busy, 1);
    n = 0;
    while (busy && n < 6000) begin
      step();
      n++;
    end
    check("to_cycles", n, 5000);

    // stop ended by deion_start in cycle 10
    start();
    stop();
    repeat (10) step();
    check("dd_busy_c10", busy, 1);
    deion();
    check("dd_busy_c11", busy, 0);

    // pulse_done and deion_start together on the last pulse
    wr_entry(2'd0, 16'h0001, 16'd20, 16'd50, 16'd100, 16'd1);
    start();
    pulse_done = 1'b1; deion_start = 1'b1;
    step();
    pulse_done = 1'b0; deion_start = 1'b0;
    check("imm_ip", Ip, 30);
    check("imm_idx", active_idx, 1);
    check("imm_cnt", pulse_cnt, 0);
    check("imm_state", dbg_state, ST_RUN);
    stop();
    deion();

    // unlimited entry
    wr_entry(2'd0, 16'h0001, 16'd99, 16'd50, 16'd100, 16'd0);
    start();
    repeat (1000) pulse();
    check("unl_idx", active_idx, 0);
    check("unl_cnt", pulse_cnt, 1000);
    check("unl_is_machine", is_machine, 1);
    check("unl_state", dbg_state, ST_RUN);
    stop();
    check("unl_stop", is_machine, 0);
    deion();
    check("unl_idle", busy, 0);

    // start together with stop in IDLE
    cmd_start = 1'b1; cmd_stop = 1'b1;
    step();
    cmd_start = 1'b0; cmd_stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_is_machine", is_machine, 0);

    // fault beats stop: stop alone would not latch the fault
    start();
    fault_in = 1'b1; cmd_stop = 1'b1;
    step();
    fault_in = 1'b0; cmd_stop = 1'b0;
    check("fs_latched", fault_latched, 1);
    deion();

    // reset mid-operation clears outputs and table
    start();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_is_machine", is_machine, 0);
    check("mr_ip", Ip, 0);
    check("mr_busy", busy, 0);
    check("mr_fault", fault_latched, 0);
    start();
    check("mr_table_ip", Ip, 0);
    check("mr_table_wave", waveform, 0);
    stop();
    deion();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
